// File: rtl/quad_gray_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | quad_gray_pkg                                                              |
// | Gray code constants, FSM encoding and step classifier for quad_gray_decoder|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package quad_gray_pkg;

    localparam logic [1:0] G0 = 2'b00;
    localparam logic [1:0] G1 = 2'b01;
    localparam logic [1:0] G2 = 2'b11;
    localparam logic [1:0] G3 = 2'b10;

    typedef enum logic [0:0] {
        PRIME = 1'b0,
        TRACK = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        UP      = 2'd1,
        DOWN    = 2'd2,
        ILLEGAL = 2'd3
    } step_t;

    // Position of a Gray code within the 4-step cycle.
    function automatic logic [1:0] gray_pos(input logic [1:0] g);
        logic [1:0] p;
        p = 2'd0;
        case (g)
            G0:      p = 2'd0;
            G1:      p = 2'd1;
            G2:      p = 2'd2;
            G3:      p = 2'd3;
            default: p = 2'd0;
        endcase
        return p;
    endfunction

    // Positional difference mod 4: +1 up, -1 down, 2 is a two-bit jump.
    function automatic step_t gray_step(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] d;
        step_t      cls;
        d   = gray_pos(cur) - gray_pos(prev);
        cls = NONE;
        case (d)
            2'd0:    cls = NONE;
            2'd1:    cls = UP;
            2'd3:    cls = DOWN;
            default: cls = ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gray_sync                                                                  |
// | SYNC_STAGES-deep 2-bit synchroniser; GLITCH_FILTER_EN adds a hold filter.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module gray_sync
    import quad_gray_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in,
    output logic [1:0] out
);

    logic [1:0] r_sync [SYNC_STAGES];
    logic [1:0] w_sync_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= G0;
            end
        end else begin
            r_sync[0] <= in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
    logic [1:0] w_pre;
    logic [1:0] r_filt;

    // Accept a new level only once the stage feeding the output agrees with it.
    generate
        if (SYNC_STAGES > 1) begin : g_pre_chain
            assign w_pre = r_sync[SYNC_STAGES-2];
        end else begin : g_pre_in
            assign w_pre = in;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt <= G0;
        end else if (w_sync_out == w_pre) begin
            r_filt <= w_sync_out;
        end
    end

    assign out = r_filt;
`else
    assign out = w_sync_out;
`endif

endmodule
`default_nettype wire

// File: rtl/quad_gray_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | quad_gray_decoder                                                          |
// | Gray/quadrature step decoder with wrapping counter and error flags.        |
// | Optional macro GLITCH_FILTER_EN adds a one-cycle glitch filter.            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module quad_gray_decoder
    import quad_gray_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       in,
    input  logic             en,
    input  logic             err_clr,
    output logic [CNT_W-1:0] cnt,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic             err_sticky
);

    logic [1:0]       w_s;
    step_t            w_cls;
    state_t           r_state;
    logic [1:0]       r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             r_step;
    logic             r_dir;
    logic             r_err;
    logic             r_sticky;

    gray_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .out (w_s)
    );

    assign w_cls = gray_step(r_prev, w_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= PRIME;
            r_prev   <= G0;
            r_cnt    <= '0;
            r_step   <= 1'b0;
            r_dir    <= 1'b0;
            r_err    <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_step <= 1'b0;
            r_err  <= 1'b0;
            r_prev <= w_s;
            if (err_clr) begin
                r_sticky <= 1'b0;
            end
            case (r_state)
                PRIME: begin
                    r_state <= TRACK;
                end
                TRACK: begin
                    // A new error is assigned after the clear so it wins.
                    case (w_cls)
                        UP: begin
                            if (en) begin
                                r_cnt  <= r_cnt + CNT_W'(1);
                                r_step <= 1'b1;
                                r_dir  <= 1'b1;
                            end
                        end
                        DOWN: begin
                            if (en) begin
                                r_cnt  <= r_cnt - CNT_W'(1);
                                r_step <= 1'b1;
                                r_dir  <= 1'b0;
                            end
                        end
                        ILLEGAL: begin
                            r_err    <= 1'b1;
                            r_sticky <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: r_state <= PRIME;
            endcase
        end
    end

    assign cnt        = r_cnt;
    assign step       = r_step;
    assign dir        = r_dir;
    assign err        = r_err;
    assign err_sticky = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_quad_gray_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_quad_gray_decoder                                                       |
// | Directed self-checking bench for quad_gray_decoder (GLITCH_FILTER_EN aware)|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_quad_gray_decoder;

    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;
`ifdef GLITCH_FILTER_EN
    localparam int LAT = SYNC_STAGES + 1;
`else
    localparam int LAT = SYNC_STAGES;
`endif

    logic             clk = 1'b1;
    logic             rst;
    logic [1:0]       in_v;
    logic             en;
    logic             err_clr;
    logic [CNT_W-1:0] cnt;
    logic             step;
    logic             dir;
    logic             err;
    logic             err_sticky;

    int tests = 0;
    int fails = 0;

    quad_gray_decoder #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in_v),
        .en         (en),
        .err_clr    (err_clr),
        .cnt        (cnt),
        .step       (step),
        .dir        (dir),
        .err        (err),
        .err_sticky (err_sticky)
    );

    always #20 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic advance(input logic [1:0] v);
        in_v = v;
        repeat (LAT + 1) tick();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; err_clr = 1'b0; in_v = 2'b00;
        @(posedge clk);
        #1;
        tests++; if (cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", cnt); end
        tests++; if (step !== 1'b0) begin fails++; $display("FAIL reset_step got %b want 0", step); end
        tests++; if (dir !== 1'b0) begin fails++; $display("FAIL reset_dir got %b want 0", dir); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
        tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL reset_sticky got %b want 0", err_sticky); end
        #9 rst = 1'b0;
        tick();
    endtask

    task automatic test_forward();
        logic [1:0] seq [4];
        logic [7:0] expc [4];
        seq  = '{2'b01, 2'b11, 2'b10, 2'b00};
        expc = '{8'd1, 8'd2, 8'd3, 8'd4};
        for (int k = 0; k < 4; k++) begin
            in_v = seq[k];
            repeat (LAT) tick();
            tests++;
            if (step !== 1'b0) begin fails++; $display("FAIL fwd_early[%0d] step=%b want 0", k, step); end
            tick();
            tests++;
            if (step !== 1'b1 || cnt !== expc[k] || dir !== 1'b1 || err !== 1'b0) begin
                fails++;
                $display("FAIL fwd_step[%0d] step=%b cnt=%0d dir=%b err=%b want 1 %0d 1 0", k, step, cnt, dir, err, expc[k]);
            end
            tick();
            tests++;
            if (step !== 1'b0) begin fails++; $display("FAIL fwd_pulse[%0d] step=%b want 0", k, step); end
        end
    endtask

    task automatic test_reverse_wrap();
        logic [1:0] seq [6];
        logic [7:0] expc [6];
        logic       expd [6];
        seq  = '{2'b10, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
        expc = '{8'd255, 8'd0, 8'd255, 8'd254, 8'd253, 8'd252};
        expd = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        pulse_rst();
        for (int k = 0; k < 6; k++) begin
            in_v = seq[k];
            repeat (LAT) tick();
            tick();
            tests++;
            if (step !== 1'b1 || cnt !== expc[k] || dir !== expd[k]) begin
                fails++;
                $display("FAIL rev_step[%0d] step=%b cnt=%0d dir=%b want 1 %0d %b", k, step, cnt, dir, expc[k], expd[k]);
            end
        end
    endtask

    task automatic test_illegal();
        pulse_rst();
        advance(2'b01);
        advance(2'b11);
        advance(2'b10);
        tests++; if (cnt !== 8'd3) begin fails++; $display("FAIL ill_setup cnt=%0d want 3", cnt); end
        in_v = 2'b01;
        repeat (LAT) tick();
        tick();
        tests++;
        if (err !== 1'b1 || step !== 1'b0 || err_sticky !== 1'b1 || cnt !== 8'd3 || dir !== 1'b1) begin
            fails++;
            $display("FAIL ill_jump err=%b step=%b sticky=%b cnt=%0d dir=%b want 1 0 1 3 1", err, step, err_sticky, cnt, dir);
        end
        tick();
        tests++;
        if (err !== 1'b0 || err_sticky !== 1'b1) begin
            fails++; $display("FAIL ill_pulse err=%b sticky=%b want 0 1", err, err_sticky);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tests++;
        if (err_sticky !== 1'b0 || err !== 1'b0) begin
            fails++; $display("FAIL ill_clear sticky=%b err=%b want 0 0", err_sticky, err);
        end
    endtask

    task automatic test_clear_collision();
        advance(2'b00);
        tests++; if (cnt !== 8'd2) begin fails++; $display("FAIL col_setup cnt=%0d want 2", cnt); end
        in_v = 2'b11;
        repeat (LAT) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tests++;
        if (err !== 1'b1 || err_sticky !== 1'b1 || step !== 1'b0 || cnt !== 8'd2) begin
            fails++;
            $display("FAIL col_new_err err=%b sticky=%b step=%b cnt=%0d want 1 1 0 2", err, err_sticky, step, cnt);
        end
        tick();
        tests++;
        if (err !== 1'b0 || err_sticky !== 1'b1) begin
            fails++; $display("FAIL col_hold err=%b sticky=%b want 0 1", err, err_sticky);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL col_clear sticky=%b want 0", err_sticky); end
    endtask

    task automatic test_enable();
        advance(2'b10);
        advance(2'b00);
        tests++; if (cnt !== 8'd4) begin fails++; $display("FAIL en_setup cnt=%0d want 4", cnt); end
        en = 1'b0;
        in_v = 2'b01;
        repeat (LAT) tick();
        tick();
        tests++; if (step !== 1'b0 || cnt !== 8'd4) begin fails++; $display("FAIL en_off_a step=%b cnt=%0d want 0 4", step, cnt); end
        in_v = 2'b11;
        repeat (LAT) tick();
        tick();
        tests++; if (step !== 1'b0 || cnt !== 8'd4) begin fails++; $display("FAIL en_off_b step=%b cnt=%0d want 0 4", step, cnt); end
        en = 1'b1;
        in_v = 2'b10;
        repeat (LAT) tick();
        tick();
        tests++;
        if (step !== 1'b1 || cnt !== 8'd5 || dir !== 1'b1) begin
            fails++; $display("FAIL en_on step=%b cnt=%0d dir=%b want 1 5 1", step, cnt, dir);
        end
    endtask

    task automatic test_priming();
        advance(2'b11);
        tests++; if (cnt !== 8'd4 || dir !== 1'b0) begin fails++; $display("FAIL prime_setup cnt=%0d dir=%b want 4 0", cnt, dir); end
        rst = 1'b1;
        tick();
        tests++;
        if (cnt !== 8'd0 || step !== 1'b0 || dir !== 1'b0) begin
            fails++; $display("FAIL prime_rst cnt=%0d step=%b dir=%b want 0 0 0", cnt, step, dir);
        end
        rst = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            tick();
            tests++;
            if (step !== 1'b0 || cnt !== 8'd0) begin
                fails++; $display("FAIL prime_nostep[%0d] step=%b cnt=%0d want 0 0", i, step, cnt);
            end
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        in_v = 2'b10;
        repeat (LAT) tick();
        tick();
        tests++;
        if (step !== 1'b1 || cnt !== 8'd1 || dir !== 1'b1) begin
            fails++; $display("FAIL prime_first step=%b cnt=%0d dir=%b want 1 1 1", step, cnt, dir);
        end
    endtask

`ifdef GLITCH_FILTER_EN
    task automatic test_glitch();
        advance(2'b00);
        tests++; if (cnt !== 8'd2) begin fails++; $display("FAIL gl_setup cnt=%0d want 2", cnt); end
        in_v = 2'b01;
        tick();
        in_v = 2'b00;
        for (int i = 0; i < LAT + 4; i++) begin
            tick();
            tests++;
            if (step !== 1'b0 || err !== 1'b0 || cnt !== 8'd2) begin
                fails++; $display("FAIL gl_reject[%0d] step=%b err=%b cnt=%0d want 0 0 2", i, step, err, cnt);
            end
        end
        in_v = 2'b01;
        repeat (LAT) tick();
        tests++; if (step !== 1'b0) begin fails++; $display("FAIL gl_early step=%b want 0", step); end
        tick();
        tests++;
        if (step !== 1'b1 || cnt !== 8'd3) begin
            fails++; $display("FAIL gl_accept step=%b cnt=%0d want 1 3", step, cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_reverse_wrap();
        test_illegal();
        test_clear_collision();
        test_enable();
        test_priming();
`ifdef GLITCH_FILTER_EN
        test_glitch();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
